// File: rtl/eprisc_bus_decoder.sv
// eprisc_bus_decoder
//   Address decoder and transaction sequencer for the epRISC system bus.
//   A master access is accepted in IDLE, matched against REGIONS base/limit
//   windows (lowest index wins), and then walked through optional wait states
//   and an optional slave-ready handshake with a timeout. Completion is
//   signalled by a one-cycle oReady pulse. Unmapped or timed-out accesses set
//   a sticky bus error that records the offending address.
//
// Ports
//   iClock        : clock, all state on the rising edge
//   iReset        : asynchronous active-low reset
//   iAddress      : master address
//   iWrite        : master write (1) / read (0)
//   iAccess       : master access request, sampled only in IDLE
//   iSlaveData    : packed slave read data, region 0 in the LSBs
//   iSlaveReady   : per-region slave ready, used by EXTRDY regions
//   iClearError   : clears the sticky bus error (a new error wins)
//   oSelect       : one-hot slave select for the active transaction
//   oWriteStrobe  : one-hot, one-cycle write pulse in DONE
//   oData         : registered read data (0 after an error)
//   oReady        : one-cycle completion pulse in DONE or ERR
//   oBusError     : sticky bus error flag
//   oErrorAddress : address of the first unrecovered error
module eprisc_bus_decoder #(
    parameter int                         REGIONS = 4,
    parameter int                         ADDR_W  = 32,
    parameter int                         DATA_W  = 32,
    parameter logic [REGIONS*ADDR_W-1:0]  BASES   = {32'h3000, 32'h2000, 32'h1000, 32'h0},
    parameter logic [REGIONS*ADDR_W-1:0]  LIMITS  = {32'h800000, 32'h3000, 32'h2000, 32'h1000},
    parameter logic [REGIONS*4-1:0]       WAITS   = 16'h0000,
    parameter logic [REGIONS-1:0]         EXTRDY  = 4'b1000,
    parameter int                         TIMEOUT = 64
) (
    input  logic                      iClock,
    input  logic                      iReset,
    input  logic [ADDR_W-1:0]         iAddress,
    input  logic                      iWrite,
    input  logic                      iAccess,
    input  logic [REGIONS*DATA_W-1:0] iSlaveData,
    input  logic [REGIONS-1:0]        iSlaveReady,
    input  logic                      iClearError,
    output logic [REGIONS-1:0]        oSelect,
    output logic [REGIONS-1:0]        oWriteStrobe,
    output logic [DATA_W-1:0]         oData,
    output logic                      oReady,
    output logic                      oBusError,
    output logic [ADDR_W-1:0]         oErrorAddress
);

    localparam int RIDX_W = (REGIONS > 1) ? $clog2(REGIONS) : 1;
    // One counter serves both wait states (max 15) and the timeout count.
    localparam int CNT_W  = $clog2(TIMEOUT + 16) + 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_EXT  = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    logic [2:0]          state_q,   state_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;
    logic [ADDR_W-1:0]   addr_q,    addr_d;
    logic                write_q,   write_d;
    logic [RIDX_W-1:0]   region_q,  region_d;
    logic                hit_q,     hit_d;
    logic [REGIONS-1:0]  sel_q,     sel_d;
    logic [REGIONS-1:0]  strobe_q,  strobe_d;
    logic [DATA_W-1:0]   data_q,    data_d;
    logic                ready_q,   ready_d;
    logic                err_q,     err_d;
    logic [ADDR_W-1:0]   eaddr_q,   eaddr_d;

    logic                dec_hit_s;
    logic [RIDX_W-1:0]   dec_idx_s;
    logic [3:0]          dec_wait_s;
    logic                dec_ext_s;
    logic                cur_ext_s;
    logic                set_err_s;
    logic [REGIONS-1:0]  onehot_s;

    // Address decode; scanning downwards lets the lowest matching index win.
    always_comb begin
        dec_hit_s = 1'b0;
        dec_idx_s = '0;
        for (int k = REGIONS - 1; k >= 0; k--) begin
            if ((iAddress >= BASES[k*ADDR_W +: ADDR_W]) &&
                (iAddress <  LIMITS[k*ADDR_W +: ADDR_W])) begin
                dec_hit_s = 1'b1;
                dec_idx_s = RIDX_W'(k);
            end else begin
                dec_hit_s = dec_hit_s;
                dec_idx_s = dec_idx_s;
            end
        end
        dec_wait_s = WAITS[int'(dec_idx_s)*4 +: 4];
        dec_ext_s  = EXTRDY[dec_idx_s];
        cur_ext_s  = EXTRDY[region_q];
    end

    // Transaction FSM and latched request.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        write_d  = write_q;
        region_d = region_q;
        hit_d    = hit_q;
        case (state_q)
            S_IDLE: begin
                if (iAccess) begin
                    addr_d   = iAddress;
                    write_d  = iWrite;
                    region_d = dec_idx_s;
                    hit_d    = dec_hit_s;
                    cnt_d    = '0;
                    if (!dec_hit_s) begin
                        state_d = S_ERR;
                    end else if (dec_wait_s != 4'd0) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(dec_wait_s);
                    end else if (dec_ext_s) begin
                        state_d = S_EXT;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                // Leaving on the cycle that would bring the count to 0 gives
                // exactly WAITS[k] cycles in WAIT.
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = cur_ext_s ? S_EXT : S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_EXT: begin
                if (iSlaveReady[region_q]) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_W'(TIMEOUT - 1)) begin
                    state_d = S_ERR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE, S_ERR: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output next-state, derived from the next FSM state so outputs are registered.
    always_comb begin
        onehot_s  = {{(REGIONS-1){1'b0}}, 1'b1} << region_d;
        set_err_s = (state_d == S_ERR);
        ready_d   = (state_d == S_DONE) || (state_d == S_ERR);
        if (hit_d && (state_d != S_IDLE)) begin
            sel_d = onehot_s;
        end else begin
            sel_d = '0;
        end
        if ((state_d == S_DONE) && write_d) begin
            strobe_d = onehot_s;
        end else begin
            strobe_d = '0;
        end
        if (state_d == S_ERR) begin
            data_d = '0;
        end else if ((state_d == S_DONE) && !write_d) begin
            data_d = iSlaveData[int'(region_d)*DATA_W +: DATA_W];
        end else begin
            data_d = data_q;
        end
        // A new error wins over a simultaneous clear and then owns the address.
        if (set_err_s) begin
            err_d = 1'b1;
        end else if (iClearError) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
        if (set_err_s && (!err_q || iClearError)) begin
            eaddr_d = addr_d;
        end else begin
            eaddr_d = eaddr_q;
        end
    end

    // State and output registers.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            region_q <= '0;
            hit_q    <= 1'b0;
            sel_q    <= '0;
            strobe_q <= '0;
            data_q   <= '0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            eaddr_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            region_q <= region_d;
            hit_q    <= hit_d;
            sel_q    <= sel_d;
            strobe_q <= strobe_d;
            data_q   <= data_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
            eaddr_q  <= eaddr_d;
        end
    end

    assign oSelect       = sel_q;
    assign oWriteStrobe  = strobe_q;
    assign oData         = data_q;
    assign oReady        = ready_q;
    assign oBusError     = err_q;
    assign oErrorAddress = eaddr_q;

endmodule
